// File: rtl/raymarch_pkg.sv
// Shared types and screen constants for the raymarch frame scheduler.
// Holds the colour record, the scheduler FSM state and default geometry.
package raymarch_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CORDW         = 10;
  localparam int ADDR_W        = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/raymarch_result_fifo.sv
// First-word-fall-through result FIFO; dout shows the head whenever !empty.
// Ports: clk, reset, push/din, pop/dout, empty, count (entries held).
module raymarch_result_fifo
  import raymarch_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = $bits(rgb_t)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_pop;

  always_comb begin
    do_pop = pop && (cnt_q != '0);
    wp_d   = push ? wp_q + AW'(1) : wp_q;
    rp_d   = do_pop ? rp_q + AW'(1) : rp_q;
    cnt_d  = cnt_q + (AW+1)'(push)
                   - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers flush it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= din;
  end

  // Credits upstream must make a push into a full,
  // non-popping FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && cnt_q == FULL && !do_pop));
    end
  end

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/raymarch_frame_scheduler.sv
// Issues one frame of pixels into a non-stalling raymarcher and drains results.
// Ports: clk/reset, start/busy/frame_done, pix_x/pix_y, rm_*, wr_valid/ready/addr/data.
module raymarch_frame_scheduler
  import raymarch_pkg::*;
#(
  parameter int H_RES        = SCREEN_WIDTH,
  parameter int V_RES        = SCREEN_HEIGHT,
  parameter int CORDW        = raymarch_pkg::CORDW,
  parameter int ADDR_W       = raymarch_pkg::ADDR_W,
  parameter int PIPE_LATENCY = 280,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [CORDW-1:0]  pix_x,
  output logic [CORDW-1:0]  pix_y,
  input  logic [7:0]        rm_red,
  input  logic [7:0]        rm_green,
  input  logic [7:0]        rm_blue,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int L  = PIPE_LATENCY;
  localparam logic [CW:0] LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);

  state_e            state_q, state_d;
  logic [CORDW-1:0]  x_q, x_d;
  logic [CORDW-1:0]  y_q, y_d;
  logic [L-1:0]      vld_q, vld_d;
  logic [L:0]        vld_sh;
  logic [CW-1:0]     infl_q, infl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  rgb_t              fifo_dout;
  rgb_t              rm_rgb;
  logic [CW:0]       used;
  logic              issue, push, pop;
  logic              start_ok, last_pix;

  // Credits are what is left once queued and
  // in-flight results are reserved.
  always_comb begin
    used     = {1'b0, fifo_cnt} + {1'b0, infl_q};
    issue    = (state_q == RUN) && (used < LIM);
    push     = vld_q[L-1];
    pop      = !fifo_empty && wr_ready;
    start_ok = (state_q == IDLE) && start;
    last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && last_pix) state_d = DRAIN;
      DRAIN:   if (infl_q == '0 && fifo_empty)
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last pixel wraps both counters, so IDLE
  // always presents (0,0).
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start_ok) begin
      x_d = '0;
      y_d = '0;
    end else if (issue) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0
                              : y_q + CORDW'(1);
      end else begin
        x_d = x_q + CORDW'(1);
      end
    end
  end

  always_comb begin
    vld_sh = {vld_q, issue};
    vld_d  = vld_sh[L-1:0];
    infl_d = infl_q + CW'(issue) - CW'(push);
    addr_d = addr_q;
    if (start_ok)  addr_d = '0;
    else if (pop)  addr_d = addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vld_q   <= '0;
      infl_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      infl_q  <= infl_d;
      addr_q  <= addr_d;
    end
  end

  assign rm_rgb = '{r: rm_red, g: rm_green, b: rm_blue};

  raymarch_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rgb_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rm_rgb),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign wr_valid   = !fifo_empty;
  assign wr_addr    = addr_q;
  assign wr_data    = fifo_empty ? '0 : fifo_dout;

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Bench for raymarch_frame_scheduler: 4x3 frame, 8-cycle pipeline model,
// one DUT with a 16-entry FIFO and one with a 2-entry FIFO.
module tb_raymarch_frame_scheduler;

  localparam int H = 4;
  localparam int V = 3;
  localparam int L = 8;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [1:0]      start, ready;
  logic [1:0]      busy, done, wvalid;
  logic [1:0][3:0] px, py, waddr;
  logic [1:0][7:0] rr, rg, rb;
  logic [1:0][23:0] wdata;

  raymarch_frame_scheduler #(
    .H_RES(H), .V_RES(V), .CORDW(4), .ADDR_W(4),
    .PIPE_LATENCY(L), .FIFO_DEPTH(16)
  ) u0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .busy(busy[0]), .frame_done(done[0]),
    .pix_x(px[0]), .pix_y(py[0]),
    .rm_red(rr[0]), .rm_green(rg[0]), .rm_blue(rb[0]),
    .wr_valid(wvalid[0]), .wr_ready(ready[0]),
    .wr_addr(waddr[0]), .wr_data(wdata[0])
  );

  raymarch_frame_scheduler #(
    .H_RES(H), .V_RES(V), .CORDW(4), .ADDR_W(4),
    .PIPE_LATENCY(L), .FIFO_DEPTH(2)
  ) u1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .busy(busy[1]), .frame_done(done[1]),
    .pix_x(px[1]), .pix_y(py[1]),
    .rm_red(rr[1]), .rm_green(rg[1]), .rm_blue(rb[1]),
    .wr_valid(wvalid[1]), .wr_ready(ready[1]),
    .wr_addr(waddr[1]), .wr_data(wdata[1])
  );

  // Raymarcher model: colour = {x, y, A5} after L clocks.
  logic [7:0] pipe_x [2][L];
  logic [7:0] pipe_y [2][L];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      pipe_x[u][0] <= 8'(px[u]);
      pipe_y[u][0] <= 8'(py[u]);
      for (int i = 1; i < L; i++) begin
        pipe_x[u][i] <= pipe_x[u][i-1];
        pipe_y[u][i] <= pipe_y[u][i-1];
      end
    end
  end

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      rr[u] = pipe_x[u][L-1];
      rg[u] = pipe_y[u][L-1];
      rb[u] = 8'hA5;
    end
  end

  // Write monitor: logs accepted writes, frame_done and stall stability.
  logic [27:0] wq [2][$];
  int fd_cnt [2] = '{0, 0};
  int fd_at [2] = '{0, 0};
  int stab_err [2] = '{0, 0};
  logic [1:0] stall_q = '0;
  logic [1:0][27:0] hold_q;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (stall_q[u] && (!wvalid[u] ||
          {waddr[u], wdata[u]} != hold_q[u]))
        stab_err[u]++;
      stall_q[u] = wvalid[u] && !ready[u] && !reset;
      hold_q[u] = {waddr[u], wdata[u]};
      if (wvalid[u] && ready[u] && !reset)
        wq[u].push_back({waddr[u], wdata[u]});
      if (done[u] && !reset) begin
        fd_cnt[u]++;
        fd_at[u] = wq[u].size();
      end
    end
  end

  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] exp_rec(int i);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'(i % H);
    y = 8'(i / H);
    return {4'(i), x, y, 8'hA5};
  endfunction

  // mode 0: ready high; 1: ready low for hold cycles;
  // 2: ready toggles; 3: ready high, second start at c=5.
  task automatic run_frame(input int u, input int mode,
                           input int hold, input int ex,
                           input int ey);
    int wb, fb, sb, n;
    bit fin;
    wb = wq[u].size();
    fb = fd_cnt[u];
    sb = stab_err[u];
    fin = 0;
    ready[u] = (mode == 0 || mode == 3);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    chk("busy_after_start", 32'(busy[u]), 1);
    for (int c = 0; c < 400 && !fin; c++) begin
      if (mode == 1) ready[u] = (c >= hold);
      else if (mode == 2) ready[u] = c[0];
      else ready[u] = 1'b1;
      start[u] = (mode == 3 && c == 5);
      tick();
      if (mode == 1 && c == hold - 1) begin
        chk("stall_valid", 32'(wvalid[u]), 1);
        chk("stall_head", 32'({waddr[u], wdata[u]}),
            32'(exp_rec(0)));
        chk("stall_pix_x", 32'(px[u]), 32'(ex));
        chk("stall_pix_y", 32'(py[u]), 32'(ey));
        chk("stall_busy", 32'(busy[u]), 1);
      end
      if (fd_cnt[u] != fb) fin = 1;
    end
    start[u] = 1'b0;
    ready[u] = 1'b1;
    chk("frame_done_seen", 32'(fin), 1);
    repeat (3) tick();
    n = wq[u].size() - wb;
    chk("write_count", 32'(n), NPIX);
    for (int i = 0; i < NPIX && i < n; i++)
      chk("write_rec", 32'(wq[u][wb+i]),
          32'(exp_rec(i)));
    chk("frame_done_count", 32'(fd_cnt[u] - fb), 1);
    chk("done_after_last", 32'(fd_at[u] - wb), NPIX);
    chk("stall_stable", 32'(stab_err[u] - sb), 0);
    chk("busy_low_after", 32'(busy[u]), 0);
    chk("valid_low_after", 32'(wvalid[u]), 0);
  endtask

  typedef struct {
    int u;
    int mode;
    int hold;
    int ex;
    int ey;
  } vec_t;

  vec_t vt [6];

  initial begin
    int wb, fb;
    vt[0] = '{0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 40, 0, 0};
    vt[2] = '{0, 2, 0, 0, 0};
    vt[3] = '{0, 3, 0, 0, 0};
    vt[4] = '{1, 0, 0, 0, 0};
    vt[5] = '{1, 1, 30, 2, 0};

    reset = 1'b1;
    start = '0;
    ready = '1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", 32'(busy[u]), 0);
      chk("rst_done", 32'(done[u]), 0);
      chk("rst_valid", 32'(wvalid[u]), 0);
      chk("rst_addr", 32'(waddr[u]), 0);
      chk("rst_data", 32'(wdata[u]), 0);
      chk("rst_pix_x", 32'(px[u]), 0);
      chk("rst_pix_y", 32'(py[u]), 0);
    end

    for (int k = 0; k < 6; k++)
      run_frame(vt[k].u, vt[k].mode, vt[k].hold,
                vt[k].ex, vt[k].ey);

    // Reset during DRAIN with results queued.
    ready[0] = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (30) tick();
    chk("drain_valid", 32'(wvalid[0]), 1);
    chk("drain_busy", 32'(busy[0]), 1);
    wb = wq[0].size();
    fb = fd_cnt[0];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(wvalid[0]), 0);
    chk("abort_busy", 32'(busy[0]), 0);
    chk("abort_addr", 32'(waddr[0]), 0);
    ready[0] = 1'b1;
    repeat (20) tick();
    chk("abort_no_writes", 32'(wq[0].size() - wb), 0);
    chk("abort_no_done", 32'(fd_cnt[0] - fb), 0);
    run_frame(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
